// File: rtl/alu_writeback.sv
// ALU writeback: commits result/flags to A/F, AF load, EX AF,AF' and Z80 cc eval.
// Optional AF' shadow + SWAP state under ALU_WRITEBACK_SHADOW_EX_AF_EN.
module alu_writeback #(
  parameter int unsigned data_width = 8,
  parameter logic [15:0] reset_af   = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                cmd,
  input  logic [data_width-1:0]     alu_out,
  input  logic [data_width-1:0]     alu_flags,
  input  logic [data_width-1:0]     flag_mask,
  input  logic                      wr_a,
  input  logic [2*data_width-1:0]   ld_data,
  input  logic [2:0]                cc,
  output logic [data_width-1:0]     a_reg,
  output logic [data_width-1:0]     f_reg,
  output logic                      cc_true,
  output logic                      done,
  output logic                      illegal
);

  localparam logic [1:0] CMD_ALU = 2'b00;
  localparam logic [1:0] CMD_LD  = 2'b01;
  localparam logic [1:0] CMD_EX  = 2'b10;

  localparam int unsigned FS  = 7;
  localparam int unsigned FZ  = 6;
  localparam int unsigned FPV = 2;
  localparam int unsigned FC  = 0;

  logic [data_width-1:0] a_q, a_d;
  logic [data_width-1:0] f_q, f_d;
  logic                  done_q, done_d;
  logic                  ill_q, ill_d;
  logic                  accept;

`ifdef ALU_WRITEBACK_SHADOW_EX_AF_EN
  typedef enum logic {
    IDLE,
    SWAP
  } state_e;

  state_e                  state_q, state_d;
  logic [2*data_width-1:0] sh_q, sh_d;

  assign in_ready = !reset && (state_q == IDLE);
`else
  assign in_ready = !reset;
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= reset_af[15:8];
      f_q    <= reset_af[7:0];
      done_q <= 1'b0;
      ill_q  <= 1'b0;
`ifdef ALU_WRITEBACK_SHADOW_EX_AF_EN
      state_q <= IDLE;
      sh_q    <= reset_af;
`endif
    end else begin
      a_q    <= a_d;
      f_q    <= f_d;
      done_q <= done_d;
      ill_q  <= ill_d;
`ifdef ALU_WRITEBACK_SHADOW_EX_AF_EN
      state_q <= state_d;
      sh_q    <= sh_d;
`endif
    end
  end

  always_comb begin
    a_d    = a_q;
    f_d    = f_q;
    done_d = 1'b0;
    ill_d  = 1'b0;
`ifdef ALU_WRITEBACK_SHADOW_EX_AF_EN
    state_d = state_q;
    sh_d    = sh_q;
`endif
    if (accept) begin
      unique case (cmd)
        CMD_ALU: begin
          f_d    = (f_q & ~flag_mask) | (alu_flags & flag_mask);
          if (wr_a) a_d = alu_out;
          done_d = 1'b1;
        end
        CMD_LD: begin
          a_d    = ld_data[2*data_width-1:data_width];
          f_d    = ld_data[data_width-1:0];
          done_d = 1'b1;
        end
        CMD_EX: begin
`ifdef ALU_WRITEBACK_SHADOW_EX_AF_EN
          state_d = SWAP;
`else
          done_d  = 1'b1;
`endif
        end
        default: begin
          done_d = 1'b1;
          ill_d  = 1'b1;
        end
      endcase
    end
`ifdef ALU_WRITEBACK_SHADOW_EX_AF_EN
    // accept is blocked in SWAP, so the exchange never collides with a command
    if (state_q == SWAP) begin
      state_d    = IDLE;
      {a_d, f_d} = sh_q;
      sh_d       = {a_q, f_q};
      done_d     = 1'b1;
    end
`endif
  end

  always_comb begin
    cc_true = 1'b0;
    unique case (cc)
      3'b000: cc_true = !f_q[FZ];
      3'b001: cc_true = f_q[FZ];
      3'b010: cc_true = !f_q[FC];
      3'b011: cc_true = f_q[FC];
      3'b100: cc_true = !f_q[FPV];
      3'b101: cc_true = f_q[FPV];
      3'b110: cc_true = !f_q[FS];
      default: cc_true = f_q[FS];
    endcase
  end

  assign a_reg   = a_q;
  assign f_reg   = f_q;
  assign done    = done_q;
  assign illegal = ill_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: vector table plus scoreboard of committed AF.
// Expectations follow ALU_WRITEBACK_SHADOW_EX_AF_EN when it is defined.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  cmd;
  logic [7:0]  alu_out;
  logic [7:0]  alu_flags;
  logic [7:0]  flag_mask;
  logic        wr_a;
  logic [15:0] ld_data;
  logic [2:0]  cc;
  logic [7:0]  a_reg;
  logic [7:0]  f_reg;
  logic        cc_true;
  logic        done;
  logic        illegal;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [16:0] sb[$];

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cmd       (cmd),
    .alu_out   (alu_out),
    .alu_flags (alu_flags),
    .flag_mask (flag_mask),
    .wr_a      (wr_a),
    .ld_data   (ld_data),
    .cc        (cc),
    .a_reg     (a_reg),
    .f_reg     (f_reg),
    .cc_true   (cc_true),
    .done      (done),
    .illegal   (illegal)
  );

  typedef struct {
    logic [1:0]  c;
    logic [7:0]  ao;
    logic [7:0]  fl;
    logic [7:0]  mk;
    logic        wa;
    logic [15:0] ld;
    logic [2:0]  sel;
    logic [7:0]  ea;
    logic [7:0]  ef;
    logic        ei;
    logic        ecc;
    int          lat;
  } vec_t;

`ifdef ALU_WRITEBACK_SHADOW_EX_AF_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input logic [1:0] c, input logic [7:0] ao, input logic [7:0] fl,
    input logic [7:0] mk, input logic wa, input logic [15:0] ld,
    input logic [2:0] sel, input logic [7:0] ea, input logic [7:0] ef,
    input logic ei, input logic ecc, input int lat);
    vec_t v;
    v.c = c; v.ao = ao; v.fl = fl; v.mk = mk; v.wa = wa; v.ld = ld;
    v.sel = sel; v.ea = ea; v.ef = ef; v.ei = ei; v.ecc = ecc;
    v.lat = lat;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        logic [16:0] e;
        done_cnt++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_af", {a_reg, f_reg}, e[16:1]);
          chk("sb_illegal", illegal, e[0]);
        end
      end else if (illegal) begin
        chk("illegal_without_done", illegal, 32'd0);
      end
    end
  end

  task automatic apply(input vec_t v);
    int n;
    n = 0;
    while (!in_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", in_ready, 32'd1);
    cmd = v.c; alu_out = v.ao; alu_flags = v.fl; flag_mask = v.mk;
    wr_a = v.wa; ld_data = v.ld; cc = v.sel;
    in_valid = 1'b1;
    sb.push_back({v.ea, v.ef, v.ei});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ready_after_accept", in_ready, (v.lat == 1) ? 32'd1 : 32'd0);
    n = 1;
    while (!done && n < 6) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, v.lat);
    chk("cc_true", cc_true, v.ecc);
    @(posedge clk); #1;
    chk("done_pulse_width", done, 32'd0);
  endtask

  vec_t tbl[12];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, dc0;
    tbl[0]  = mkv(2'b00, 8'h0E, 8'h08, 8'hFF, 1, 16'h0, 3'b011, 8'h0E, 8'h08, 0, 0, 1);
    tbl[1]  = mkv(2'b01, 8'h00, 8'h00, 8'h00, 0, 16'h00FF, 3'b001, 8'h00, 8'hFF, 0, 1, 1);
    tbl[2]  = mkv(2'b00, 8'h77, 8'h00, 8'hFE, 0, 16'h0, 3'b011, 8'h00, 8'h01, 0, 1, 1);
    tbl[3]  = mkv(2'b11, 8'h00, 8'hFF, 8'hFF, 1, 16'hABCD, 3'b010, 8'h00, 8'h01, 1, 0, 1);
    tbl[4]  = mkv(2'b11, 8'h00, 8'h00, 8'h00, 0, 16'h0, 3'b111, 8'h00, 8'h01, 1, 0, 1);
    tbl[5]  = mkv(2'b00, 8'h80, 8'h84, 8'hF0, 1, 16'h0, 3'b111, 8'h80, 8'h81, 0, 1, 1);
    tbl[6]  = mkv(2'b00, 8'h99, 8'h7E, 8'h00, 0, 16'h0, 3'b100, 8'h80, 8'h81, 0, 1, 1);
    tbl[7]  = mkv(2'b00, 8'h3C, 8'h2C, 8'h2C, 1, 16'h0, 3'b101, 8'h3C, 8'hAD, 0, 1, 1);
    tbl[8]  = mkv(2'b01, 8'h00, 8'h00, 8'h00, 0, 16'h1234, 3'b110, 8'h12, 8'h34, 0, 1, 1);
    if (SH) tbl[9] = mkv(2'b10, 8'h0, 8'h0, 8'h0, 0, 16'h0, 3'b001, 8'hFF, 8'hFF, 0, 1, 2);
    else    tbl[9] = mkv(2'b10, 8'h0, 8'h0, 8'h0, 0, 16'h0, 3'b001, 8'h12, 8'h34, 0, 0, 1);
    tbl[10] = mkv(2'b10, 8'h0, 8'h0, 8'h0, 0, 16'h0, 3'b000, 8'h12, 8'h34, 0, 1, SH ? 2 : 1);
    tbl[11] = mkv(2'b00, 8'hFF, 8'hFF, 8'h01, 0, 16'h0, 3'b011, 8'h12, 8'h35, 0, 1, 1);

    reset = 1'b1; in_valid = 1'b0; cmd = 2'b00; alu_out = 8'h00;
    alu_flags = 8'h00; flag_mask = 8'h00; wr_a = 1'b0;
    ld_data = 16'h0000; cc = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_low", in_ready, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_illegal", illegal, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_ready_high", in_ready, 32'd1);
    chk("rst_af", {a_reg, f_reg}, 32'hFFFF);
    cc = 3'b000; #1;
    chk("rst_cc_nz", cc_true, 32'd0);
    cc = 3'b001; #1;
    chk("rst_cc_z", cc_true, 32'd1);

    foreach (tbl[i]) apply(tbl[i]);

    // EX then a commit held valid across the SWAP cycle
    dc0 = done_cnt;
    cmd = 2'b10; in_valid = 1'b1;
    sb.push_back(SH ? {8'hFF, 8'hFF, 1'b0} : {8'h12, 8'h35, 1'b0});
    @(posedge clk); #1;
    cmd = 2'b00; alu_out = 8'h55; alu_flags = 8'hAA;
    flag_mask = 8'h00; wr_a = 1'b1;
    sb.push_back(SH ? {8'h55, 8'hFF, 1'b0} : {8'h55, 8'h35, 1'b0});
    n = 0;
    while (!in_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("hold_wait_cycles", n, SH ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done_count", done_cnt - dc0, 32'd2);
    chk("hold_af", {a_reg, f_reg}, SH ? 32'h55FF : 32'h5535);

    // reset asserted in the SWAP cycle
    apply(mkv(2'b01, 8'h0, 8'h0, 8'h0, 0, 16'h1234, 3'b000, 8'h12, 8'h34, 0, 1, 1));
    cmd = 2'b10; in_valid = 1'b1;
    sb.push_back({8'h12, 8'h34, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("swap_rst_ready_low", in_ready, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    #1;
    chk("swap_rst_af", {a_reg, f_reg}, 32'hFFFF);
    chk("swap_rst_done", done, 32'd0);
    chk("swap_rst_ready", in_ready, 32'd1);
    apply(mkv(2'b10, 8'h0, 8'h0, 8'h0, 0, 16'h0, 3'b001, 8'hFF, 8'hFF, 0, 1, SH ? 2 : 1));
    apply(mkv(2'b11, 8'h11, 8'h22, 8'hFF, 1, 16'h5678, 3'b000, 8'hFF, 8'hFF, 1, 0, 1));

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Downstream stage of the 8-bit ALU. Consumes the ALU result byte and its Z80-layout status flags.
- Commits them into the architectural accumulator A and flag register F under a per-flag update mask.
- Provides the EX AF,AF' shadow swap and a direct AF load path.
- Evaluates the eight Z80 condition codes from the committed F for the control unit.

Parameters:
- data_width, 8, width of A, F and the ALU result; only 8 is supported.
- reset_af, 16'hFFFF, value loaded into AF (and AF') on reset. High byte goes to A, low byte to F.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents a command this cycle.
- in_ready  output  1  block can accept a command this cycle.
- cmd  input  2  00 ALU commit, 01 load AF, 10 EX AF,AF', 11 reserved.
- alu_out  input  8  ALU result byte.
- alu_flags  input  8  ALU status flags in F layout: bit7 S, bit6 Z, bit5 Y, bit4 H, bit3 X, bit2 P/V, bit1 N, bit0 C.
- flag_mask  input  8  1 = take that bit from alu_flags; 0 = keep the current F bit.
- wr_a  input  1  ALU commit also writes alu_out to A. Set to 0 for CP/BIT-style ops.
- ld_data  input  16  AF value for cmd 01.
- cc  input  3  condition select: 000 NZ, 001 Z, 010 NC, 011 C, 100 PO, 101 PE, 110 P, 111 M.
- a_reg  output  8  committed accumulator.
- f_reg  output  8  committed flags.
- cc_true  output  1  combinational result of cc evaluated against f_reg.
- done  output  1  one-cycle pulse when a command completes.
- illegal  output  1  one-cycle pulse, coincident with done, for cmd 11.

Behaviour:
- Reset (synchronous, dominates everything):
  - a_reg/f_reg = reset_af; shadow AF' = reset_af.
  - state = IDLE; done = 0; illegal = 0.
  - in_ready = 0 while reset is high, 1 on the first cycle after release.
- Handshake:
  - A command is accepted on a rising edge where in_valid && in_ready.
  - Inputs are sampled only at acceptance.
  - With in_ready low, in_valid is ignored; upstream holds its command.
- FSM states:
  - IDLE: in_ready = 1.
  - SWAP: in_ready = 0, lasts exactly one cycle.
- Transitions:
  - IDLE, accept cmd 10 with EX_AF_EN defined: go to SWAP.
  - SWAP: go to IDLE unconditionally.
  - All other accepts: stay in IDLE.
- cmd 00 (ALU commit), at the accepting edge:
  - f_reg <= (f_reg & ~flag_mask) | (alu_flags & flag_mask).
  - If wr_a = 1, a_reg <= alu_out; otherwise A is unchanged.
  - done is high for the following cycle (latency 1).
  - Back-to-back commits at full rate; each one sees the previous commit's f_reg.
- cmd 01 (load AF): a_reg <= ld_data[15:8], f_reg <= ld_data[7:0]. Masks are ignored. Latency 1.
- cmd 10 (EX AF,AF'):
  - The accepting edge enters SWAP.
  - The SWAP-exit edge exchanges {a_reg,f_reg} with AF'.
  - done is high the cycle after SWAP (latency 2). in_ready is low for exactly one cycle.
- cmd 11: no state change; done and illegal pulse together one cycle after acceptance.
- cc_true:
  - Purely combinational from the current f_reg.
  - Reflects a commit starting the cycle after the commit edge; there is no bypass of in-flight data.
- Reset during SWAP: the swap is abandoned and all registers take reset values.
- No ALU arithmetic is performed here. The block never modifies alu_flags bits itself, including the undocumented X/Y bits, which pass through under the mask.

Optional Feature:
- Macro: ALU_WRITEBACK_SHADOW_EX_AF_EN.
- Defined: AF' shadow register and SWAP state exist as described.
- Undefined:
  - No shadow storage and no SWAP state.
  - cmd 10 is accepted, leaves A/F unchanged, and pulses done after 1 cycle.
  - illegal stays low for cmd 10.
  - in_ready is constant 1 outside reset.

Test Plan:
- Reset held 2 cycles, then released -> a_reg=FF, f_reg=FF, in_ready=1 the cycle after release; cc=000 (NZ) gives cc_true=0, cc=001 (Z) gives 1.
- ALU commit alu_out=0E, alu_flags=08, flag_mask=FF, wr_a=1 -> next cycle a_reg=0E, f_reg=08, done high exactly 1 cycle; cc=011 (C) gives 0.
- Start from f_reg=FF; commit alu_flags=00, flag_mask=FE, wr_a=0 -> f_reg=01, a_reg unchanged; cc=011 gives 1, cc=010 gives 0; cc=111 (M) gives 0.
- Load AF=1234, then EX, then EX, with macro defined:
  - After the first EX: in_ready low 1 cycle, then a_reg=FF, f_reg=FF, done 2 cycles after acceptance.
  - After the second EX: a_reg=12, f_reg=34.
- During SWAP, hold in_valid=1 with cmd 00, alu_out=55, mask=00, wr_a=1 -> accepted only on the first IDLE cycle; exactly one done; a_reg=55.
- Assert reset in the SWAP cycle after loading AF=1234 -> AF=FFFF, subsequent EX yields FFFF (shadow also reset). cmd 11 -> done and illegal pulse together, AF unchanged.
